// File: rtl/chaining_scoreboard.sv
// chaining_scoreboard: tracks in-flight vector instruction records and the element groups
// already written back, so later instructions can chain on partially completed results.
module chaining_scoreboard #(
  parameter int ENTRIES = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic                           alloc_bits_vd_valid,
  input  logic [4:0]                     alloc_bits_vd_bits,
  input  logic                           alloc_bits_vs1_valid,
  input  logic [4:0]                     alloc_bits_vs1_bits,
  input  logic [4:0]                     alloc_bits_vs2,
  input  logic [2:0]                     alloc_bits_instIndex,
  input  logic                           alloc_bits_gather,
  input  logic                           alloc_bits_gather16,
  input  logic                           alloc_bits_onlyRead,
  input  logic                           write_valid,
  input  logic [2:0]                     write_instIndex,
  input  logic [7:0]                     write_mask,
  input  logic                           release_valid,
  input  logic [2:0]                     release_instIndex,
  output logic [ENTRIES-1:0]             record_valid,
  output logic [ENTRIES-1:0]             record_bits_vd_valid,
  output logic [ENTRIES*5-1:0]           record_bits_vd_bits,
  output logic [ENTRIES-1:0]             record_bits_vs1_valid,
  output logic [ENTRIES*5-1:0]           record_bits_vs1_bits,
  output logic [ENTRIES*5-1:0]           record_bits_vs2,
  output logic [ENTRIES*3-1:0]           record_bits_instIndex,
  output logic [ENTRIES-1:0]             record_bits_gather,
  output logic [ENTRIES-1:0]             record_bits_gather16,
  output logic [ENTRIES-1:0]             record_bits_onlyRead,
  output logic [ENTRIES*8-1:0]           record_bits_elementMask,
  output logic [$clog2(ENTRIES+1)-1:0]   occupancy,
  output logic                           full
);
  localparam int OW = $clog2(ENTRIES + 1);
  typedef struct packed {
    logic       vd_valid;
    logic [4:0] vd_bits;
    logic       vs1_valid;
    logic [4:0] vs1_bits;
    logic [4:0] vs2;
    logic [2:0] inst;
    logic       gather;
    logic       gather16;
    logic       only_read;
  } rec_t;
  rec_t               w_new;
  logic [ENTRIES-1:0] w_valid, w_free, w_first, w_hit, w_take;
  assign w_new = {alloc_bits_vd_valid, alloc_bits_vd_bits, alloc_bits_vs1_valid, alloc_bits_vs1_bits,
                  alloc_bits_vs2, alloc_bits_instIndex, alloc_bits_gather, alloc_bits_gather16,
                  alloc_bits_onlyRead};
  assign w_free  = ~w_valid;
  assign w_first = w_free & (~w_free + ENTRIES'(1));
  assign alloc_ready = |w_free & ~|w_hit;
  assign w_take = (alloc_valid & alloc_ready) ? w_first : '0;
  assign record_valid = w_valid;
  assign full = occupancy == OW'(ENTRIES);
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < ENTRIES; i++) occupancy = occupancy + OW'(w_valid[i]);
  end
  for (genvar g = 0; g < ENTRIES; g++) begin : g_slot
    logic       r_v;
    rec_t       r_r;
    logic [7:0] r_m;
    logic       w_wr, w_rel;
    assign w_valid[g] = r_v;
    assign w_hit[g]   = r_v & (r_r.inst == alloc_bits_instIndex);
    assign w_wr       = r_v & write_valid & (r_r.inst == write_instIndex);
    assign w_rel      = r_v & release_valid & (r_r.inst == release_instIndex);
    // an allocating slot is invalid, so it never coincides with a write or release
    always_ff @(posedge clock or posedge reset)
      if (reset) begin
        r_v <= 1'b0;
        r_r <= '0;
        r_m <= '0;
      end else if (w_take[g]) begin
        r_v <= 1'b1;
        r_r <= w_new;
        r_m <= '0;
      end else if (w_rel) begin
        r_v <= 1'b0;
      end else if (w_wr) begin
        r_m <= r_m | write_mask;
      end
    assign record_bits_vd_valid[g]         = r_r.vd_valid;
    assign record_bits_vd_bits[5*g +: 5]   = r_r.vd_bits;
    assign record_bits_vs1_valid[g]        = r_r.vs1_valid;
    assign record_bits_vs1_bits[5*g +: 5]  = r_r.vs1_bits;
    assign record_bits_vs2[5*g +: 5]       = r_r.vs2;
    assign record_bits_instIndex[3*g +: 3] = r_r.inst;
    assign record_bits_gather[g]           = r_r.gather;
    assign record_bits_gather16[g]         = r_r.gather16;
    assign record_bits_onlyRead[g]         = r_r.only_read;
    assign record_bits_elementMask[8*g +: 8] = r_m;
  end
endmodule

// File: tb/tb_chaining_scoreboard.sv
// tb_chaining_scoreboard: random and directed stimulus against a record-table model; a monitor
// pops expected cycle images and compares them with the DUT outputs.
module tb_chaining_scoreboard;
  logic clock = 0, reset = 0;
  logic alloc_valid = 0, alloc_ready;
  logic a_vdv = 0, a_vs1v = 0, a_g = 0, a_g16 = 0, a_ro = 0;
  logic [4:0] a_vd = 0, a_vs1 = 0, a_vs2 = 0;
  logic [2:0] a_inst = 0, w_inst = 0, r_inst = 0;
  logic write_valid = 0, release_valid = 0;
  logic [7:0] w_mask = 0;
  logic [3:0] rv, vdv, vs1v, g, g16, ro;
  logic [19:0] vd, vs1, vs2;
  logic [11:0] inst;
  logic [31:0] emask;
  logic [2:0] occ;
  logic full;

  chaining_scoreboard #(.ENTRIES(4)) dut (
    .clock(clock), .reset(reset), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_bits_vd_valid(a_vdv), .alloc_bits_vd_bits(a_vd), .alloc_bits_vs1_valid(a_vs1v),
    .alloc_bits_vs1_bits(a_vs1), .alloc_bits_vs2(a_vs2), .alloc_bits_instIndex(a_inst),
    .alloc_bits_gather(a_g), .alloc_bits_gather16(a_g16), .alloc_bits_onlyRead(a_ro),
    .write_valid(write_valid), .write_instIndex(w_inst), .write_mask(w_mask),
    .release_valid(release_valid), .release_instIndex(r_inst),
    .record_valid(rv), .record_bits_vd_valid(vdv), .record_bits_vd_bits(vd),
    .record_bits_vs1_valid(vs1v), .record_bits_vs1_bits(vs1), .record_bits_vs2(vs2),
    .record_bits_instIndex(inst), .record_bits_gather(g), .record_bits_gather16(g16),
    .record_bits_onlyRead(ro), .record_bits_elementMask(emask), .occupancy(occ), .full(full)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit v;
    logic [2:0] inst;
    logic vdv, vs1v, g, g16, ro;
    logic [4:0] vd, vs1, vs2;
    logic [7:0] mask;
  } slot_t;
  typedef struct {
    logic rdy, full;
    logic [2:0] occ;
    logic [3:0] v;
    logic [31:0] mask;
    logic [11:0] inst;
    logic [19:0] vd, vs1, vs2;
    logic [19:0] flags;
  } exp_t;

  slot_t m[4];
  exp_t q[$];
  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [19:0] pack_flags(input logic [3:0] a, b, c, d, e);
    return {a, b, c, d, e};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = '{default: 0};
  endtask

  task automatic step(input bit av, input logic [2:0] ai, input logic [4:0] avd,
                      input bit wv, input logic [2:0] wi, input logic [7:0] wm,
                      input bit relv, input logic [2:0] ri);
    slot_t n[4];
    exp_t e;
    int cnt, fs;
    bit dup;
    @(posedge clock); #1;
    alloc_valid = av; a_inst = ai; a_vd = avd;
    a_vdv = 1'($urandom); a_vs1v = 1'($urandom); a_vs1 = 5'($urandom); a_vs2 = 5'($urandom);
    a_g = 1'($urandom); a_g16 = 1'($urandom); a_ro = 1'($urandom);
    write_valid = wv; w_inst = wi; w_mask = wm;
    release_valid = relv; r_inst = ri;
    cnt = 0; dup = 0; fs = -1;
    for (int i = 0; i < 4; i++) begin
      if (m[i].v) cnt++;
      if (m[i].v && m[i].inst == ai) dup = 1;
      if (!m[i].v && fs < 0) fs = i;
    end
    e.rdy = (cnt < 4) && !dup;
    n = m;
    for (int i = 0; i < 4; i++)
      if (m[i].v && relv && m[i].inst == ri) n[i].v = 0;
      else if (m[i].v && wv && m[i].inst == wi) n[i].mask = m[i].mask | wm;
    if (av && e.rdy)
      n[fs] = '{v: 1, inst: ai, vdv: a_vdv, vs1v: a_vs1v, g: a_g, g16: a_g16, ro: a_ro,
                vd: avd, vs1: a_vs1, vs2: a_vs2, mask: 8'h00};
    m = n;
    cnt = 0;
    e.flags = '0;
    for (int i = 0; i < 4; i++) begin
      e.v[i] = m[i].v;
      if (m[i].v) cnt++;
      e.mask[8*i +: 8] = m[i].mask;
      e.inst[3*i +: 3] = m[i].inst;
      e.vd[5*i +: 5] = m[i].vd;
      e.vs1[5*i +: 5] = m[i].vs1;
      e.vs2[5*i +: 5] = m[i].vs2;
      e.flags[16+i] = m[i].vdv; e.flags[12+i] = m[i].vs1v; e.flags[8+i] = m[i].g;
      e.flags[4+i] = m[i].g16; e.flags[i] = m[i].ro;
    end
    e.occ = 3'(cnt);
    e.full = cnt == 4;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; write_valid = 0; release_valid = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("alloc_ready", 64'(alloc_ready), 64'(e.rdy));
        @(posedge clock); #2;
        chk("record_valid", 64'(rv), 64'(e.v));
        chk("occupancy", 64'(occ), 64'(e.occ));
        chk("full", 64'(full), 64'(e.full));
        chk("elementMask", 64'(emask), 64'(e.mask));
        chk("instIndex", 64'(inst), 64'(e.inst));
        chk("vd_bits", 64'(vd), 64'(e.vd));
        chk("vs1_bits", 64'(vs1), 64'(e.vs1));
        chk("vs2", 64'(vs2), 64'(e.vs2));
        chk("flags", 64'(pack_flags(vdv, vs1v, g, g16, ro)), 64'(e.flags));
      end
    end
  end

  task automatic drain();
    int k = 0;
    while (q.size() > 0 && k < 10) begin
      @(negedge clock);
      k++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(posedge clock); #3;
  endtask

  initial begin
    model_reset();
    #2 reset = 1;
    #1;
    chk("rst_valid", 64'(rv), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ready", 64'(alloc_ready), 64'd1);
    repeat (2) @(negedge clock);
    reset = 0;
    step(1, 3, 5'd8, 0, 0, 8'h00, 0, 0);
    step(0, 0, 0, 1, 3, 8'h0F, 0, 0);
    step(0, 0, 0, 1, 3, 8'hF0, 0, 0);
    step(0, 0, 0, 1, 6, 8'hAA, 0, 0);
    step(0, 0, 0, 0, 0, 8'h00, 1, 3);
    for (int i = 0; i < 4; i++) step(1, 3'(i), 5'(i + 10), 0, 0, 8'h00, 0, 0);
    step(1, 4, 5'd20, 0, 0, 8'h00, 1, 1);
    step(1, 4, 5'd20, 0, 0, 8'h00, 0, 0);
    step(1, 2, 5'd21, 0, 0, 8'h00, 1, 4);
    step(1, 2, 5'd21, 0, 0, 8'h00, 0, 0);
    step(0, 0, 0, 1, 0, 8'h01, 1, 0);
    step(1, 5, 5'd22, 1, 2, 8'h33, 1, 3);
    step(1, 6, 5'd23, 1, 6, 8'hFF, 0, 0);
    drain();
    idle_inputs();
    chk("pre_rst_occ", 64'(occ), 64'd3);
    reset = 1;
    model_reset();
    #1;
    chk("async_rst_valid", 64'(rv), 64'd0);
    chk("async_rst_occ", 64'(occ), 64'd0);
    chk("async_rst_mask", 64'(emask), 64'd0);
    alloc_valid = 1; a_inst = 3'd7;
    @(posedge clock); #1;
    chk("rst_ignores_alloc", 64'(rv), 64'd0);
    idle_inputs();
    @(negedge clock);
    reset = 0;
    step(1, 7, 5'd30, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(9) < 6, 3'($urandom), 5'($urandom),
           1'($urandom), 3'($urandom), 8'($urandom),
           $urandom_range(9) < 3, 3'($urandom));
    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/chaining_scoreboard.md
CHAINING_SCOREBOARD -- requirements
Module: chaining_scoreboard

Interface
REQ-001 The parameter SHALL be: ENTRIES, default 4, number of in-flight instruction records held.
REQ-002 The port list SHALL begin: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 The port list SHALL continue: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 alloc_valid  input  1  issue offers a new record.
REQ-005 alloc_ready  output  1  a slot can accept the offered record.
REQ-006 alloc_bits_{vd_valid 1, vd_bits 5, vs1_valid 1, vs1_bits 5, vs2 5, instIndex 3, gather 1, gather16 1, onlyRead 1}  input  record fields to store.
REQ-007 write_valid  input  1; write_instIndex  input  3; write_mask  input  8  element groups completed by a lane write.
REQ-008 release_valid  input  1; release_instIndex  input  3  instruction retired; free its record.
REQ-009 record_valid  output  ENTRIES  per-slot valid; record_bits_* outputs SHALL be flattened per slot (ENTRIES x field width), same fields as REQ-006 plus elementMask 8.
REQ-010 occupancy  output  clog2(ENTRIES+1)  valid slot count; full  output  1  all slots valid.

Function
REQ-011 Every output SHALL be driven only from registered state, with no combinational path from the current cycle's inputs, except alloc_ready.
REQ-012 alloc_ready SHALL be 1 iff at least one slot is invalid AND no valid slot holds instIndex == alloc_bits_instIndex; both checks use registered state only.
REQ-013 An alloc handshake (alloc_valid & alloc_ready) SHALL write the lowest-numbered invalid slot next edge: fields copied, elementMask = 8'h00, record_valid set.
REQ-014 A write_valid SHALL OR write_mask into elementMask of the valid slot whose instIndex == write_instIndex; if no slot matches, the write SHALL be dropped with no state change.
REQ-015 A release_valid SHALL clear record_valid of the slot whose instIndex == release_instIndex, next edge; other fields hold stale values; no match -> no effect.
REQ-016 Same-cycle release and write to one slot: release SHALL win; slot invalid next cycle.
REQ-017 A slot released in cycle N SHALL NOT be allocatable in cycle N (alloc_ready from pre-release state); allocatable from N+1.
REQ-018 A write in the same cycle as the alloc of its instIndex SHALL be dropped (no valid slot yet matches).
REQ-019 Alloc, write (other slot) and release (third slot) SHALL all take effect in one cycle independently.
REQ-020 elementMask bits SHALL be monotonic (only set) while the slot is valid.
REQ-021 occupancy SHALL equal popcount(record_valid) every cycle; full = (occupancy == ENTRIES).
REQ-022 Uniqueness invariant: at most one valid slot per instIndex value at all times.
REQ-023 Latency: alloc/write/release SHALL be visible on record outputs exactly one cycle after the input edge.

Reset
REQ-024 On reset assertion, record_valid, all record_bits_* fields, occupancy and full SHALL go to 0 asynchronously; alloc_ready SHALL read 1.
REQ-025 Reset mid-operation SHALL discard all records; inputs sampled during reset SHALL be ignored.
REQ-026 First edge after reset deassertion SHALL accept an alloc.

Verification
REQ-027 Alloc instIndex 3, vd 5'd8 -> next cycle slot0 valid, vd_bits 8, elementMask 8'h00, occupancy 1.
REQ-028 Writes to inst 3 with masks 8'h0F then 8'hF0 -> elementMask 8'h0F then 8'hFF; write to inst 6 (absent) -> no change.
REQ-029 Fill 4 slots (inst 0..3) -> full=1, alloc_ready=0; alloc inst 4 held valid; release inst 1 -> alloc accepted the cycle after release, lands in slot1.
REQ-030 Alloc inst 2 while inst 2 valid -> alloc_ready=0, no slot written.
REQ-031 Same cycle: write 8'h01 and release inst 0 -> slot0 invalid next cycle, occupancy decremented by 1.
REQ-032 Reset asserted mid-cycle with 3 valid slots -> record_valid 0 immediately, occupancy 0, before next clock edge.
